// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, output bundle and default timing for the PLL reset sequencer.
package pll_ctrl_pkg;

    localparam int unsigned RST_PULSE_CYC_DFLT    = 16;
    localparam int unsigned LOCK_TIMEOUT_CYC_DFLT = 50000;
    localparam int unsigned STABLE_CYC_DFLT       = 1024;
    localparam int unsigned MAX_RETRY_DFLT        = 3;
    localparam int unsigned RELOCK_W              = 8;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic pll_ok;
        logic pll_fail;
    } pll_out_t;

    localparam pll_out_t OUT_RESET = '{pll_rst: 1'b1, sys_rst: 1'b1, pll_ok: 1'b0, pll_fail: 1'b0};

    // Output levels that hold while the FSM sits in a given state.
    function automatic pll_out_t decode_outputs(input pll_state_e st);
        pll_out_t o;
        o = OUT_RESET;
        case (st)
            ST_PLL_RST:              o = OUT_RESET;
            ST_WAIT_LOCK, ST_STABLE: o.pll_rst = 1'b0;
            ST_RUN:                  o = '{pll_rst: 1'b0, sys_rst: 1'b0, pll_ok: 1'b1, pll_fail: 1'b0};
            ST_FAIL:                 o.pll_fail = 1'b1;
            default:                 o = OUT_RESET;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Capture then re-register to let metastability settle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock wait, lock qualification and downstream reset release.
module pll_reset_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = RST_PULSE_CYC_DFLT,
    parameter int unsigned LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DFLT,
    parameter int unsigned STABLE_CYC       = STABLE_CYC_DFLT,
    parameter int unsigned MAX_RETRY        = MAX_RETRY_DFLT
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                retry_req,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                pll_ok,
    output logic                pll_fail,
    output logic [RELOCK_W-1:0] relock_cnt
);

    localparam int unsigned RST_W   = $clog2(RST_PULSE_CYC + 1);
    localparam int unsigned TO_W    = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int unsigned STB_W   = $clog2(STABLE_CYC + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

    pll_state_e          r_state;
    pll_state_e          w_next;
    logic [RST_W-1:0]    r_rst_cnt;
    logic [RST_W-1:0]    w_rst_cnt_nxt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [TO_W-1:0]     w_to_cnt_nxt;
    logic [STB_W-1:0]    r_stb_cnt;
    logic [STB_W-1:0]    w_stb_cnt_nxt;
    logic [RETRY_W-1:0]  r_retry_cnt;
    logic [RETRY_W-1:0]  w_retry_nxt;
    logic [RELOCK_W-1:0] r_relock_cnt;
    logic [RELOCK_W-1:0] w_relock_nxt;
    pll_out_t            r_out;
    logic                w_locked_s;

    sync_2ff u_lock_sync (
        .i_clk (refclk),
        .i_rst (rst),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    // State, counters and next-state-decoded outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_PLL_RST;
            r_rst_cnt    <= '0;
            r_to_cnt     <= '0;
            r_stb_cnt    <= '0;
            r_retry_cnt  <= '0;
            r_relock_cnt <= '0;
            r_out        <= OUT_RESET;
        end else begin
            r_state      <= w_next;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_stb_cnt    <= w_stb_cnt_nxt;
            r_retry_cnt  <= w_retry_nxt;
            r_relock_cnt <= w_relock_nxt;
            r_out        <= decode_outputs(w_next);
        end
    end

    // Next state; phase counters default to zero so every state entry starts clean.
    always_comb begin
        w_next        = r_state;
        w_rst_cnt_nxt = '0;
        w_to_cnt_nxt  = '0;
        w_stb_cnt_nxt = '0;
        w_retry_nxt   = r_retry_cnt;
        w_relock_nxt  = r_relock_cnt;
        case (r_state)
            ST_PLL_RST: begin
                if (r_rst_cnt == RST_W'(RST_PULSE_CYC - 1)) begin
                    w_next = ST_WAIT_LOCK;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_next = ST_STABLE;
                end else if (r_to_cnt == TO_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    w_retry_nxt = r_retry_cnt + RETRY_W'(1);
                    w_next      = (r_retry_cnt == RETRY_W'(MAX_RETRY - 1)) ? ST_FAIL : ST_PLL_RST;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            ST_STABLE: begin
                if (!w_locked_s) begin
                    w_next = ST_WAIT_LOCK;
                end else if (r_stb_cnt == STB_W'(STABLE_CYC - 1)) begin
                    w_next = ST_RUN;
                end else begin
                    w_stb_cnt_nxt = r_stb_cnt + STB_W'(1);
                end
            end
            ST_RUN: begin
                w_retry_nxt = '0;
                if (!w_locked_s) begin
                    w_next = ST_PLL_RST;
                    if (r_relock_cnt != RELOCK_MAX) begin
                        w_relock_nxt = r_relock_cnt + RELOCK_W'(1);
                    end
                end
            end
            ST_FAIL: begin
                if (retry_req) begin
                    w_retry_nxt = '0;
                    w_next      = ST_PLL_RST;
                end
            end
            default: w_next = ST_PLL_RST;
        endcase
    end

    assign pll_rst    = r_out.pll_rst;
    assign sys_rst    = r_out.sys_rst;
    assign pll_ok     = r_out.pll_ok;
    assign pll_fail   = r_out.pll_fail;
    assign relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: directed scenarios plus random lock/retry stimulus against a phase model.
module tb_pll_reset_sequencer;

    localparam int P_RST   = 4;
    localparam int P_TMO   = 20;
    localparam int P_STB   = 8;
    localparam int P_RETRY = 3;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       retry_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       pll_ok;
    logic       pll_fail;
    logic [7:0] relock_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYC    (P_RST),
        .LOCK_TIMEOUT_CYC (P_TMO),
        .STABLE_CYC       (P_STB),
        .MAX_RETRY        (P_RETRY)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .retry_req  (retry_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .pll_ok     (pll_ok),
        .pll_fail   (pll_fail),
        .relock_cnt (relock_cnt)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    // Phase model: what the sequencer is doing and how long it has been doing it.
    typedef enum int {PH_PULSE, PH_WAIT, PH_SETTLE, PH_RUN, PH_FAIL} phase_t;
    phase_t     m_phase;
    int         m_elapsed;
    int         m_retries;
    int         m_relocks;
    logic [1:0] m_pipe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void enter(input phase_t ph);
        m_phase   = ph;
        m_elapsed = 0;
    endfunction

    function automatic void model_reset();
        enter(PH_PULSE);
        m_retries = 0;
        m_relocks = 0;
        m_pipe    = 2'b00;
    endfunction

    // One refclk edge: decisions use the lock level seen two edges earlier.
    function automatic void model_step(input logic lk, input logic rr);
        logic ls;
        ls     = m_pipe[1];
        m_pipe = {m_pipe[0], lk};
        case (m_phase)
            PH_PULSE: begin
                m_elapsed++;
                if (m_elapsed == P_RST) enter(PH_WAIT);
            end
            PH_WAIT: begin
                if (ls) enter(PH_SETTLE);
                else begin
                    m_elapsed++;
                    if (m_elapsed == P_TMO) begin
                        m_retries++;
                        enter((m_retries == P_RETRY) ? PH_FAIL : PH_PULSE);
                    end
                end
            end
            PH_SETTLE: begin
                if (!ls) enter(PH_WAIT);
                else begin
                    m_elapsed++;
                    if (m_elapsed == P_STB) enter(PH_RUN);
                end
            end
            PH_RUN: begin
                m_retries = 0;
                if (!ls) begin
                    if (m_relocks < 255) m_relocks++;
                    enter(PH_PULSE);
                end
            end
            PH_FAIL: begin
                if (rr) begin
                    m_retries = 0;
                    enter(PH_PULSE);
                end
            end
            default: enter(PH_PULSE);
        endcase
    endfunction

    task automatic check_all();
        check("pll_rst",    32'(pll_rst),    32'(m_phase == PH_PULSE || m_phase == PH_FAIL));
        check("sys_rst",    32'(sys_rst),    32'(m_phase != PH_RUN));
        check("pll_ok",     32'(pll_ok),     32'(m_phase == PH_RUN));
        check("pll_fail",   32'(pll_fail),   32'(m_phase == PH_FAIL));
        check("relock_cnt", 32'(relock_cnt), 32'(m_relocks));
    endtask

    // Called at a falling edge: drive, take one rising edge, then check at the next falling edge.
    task automatic tick(input logic lk, input logic rr);
        pll_locked = lk;
        retry_req  = rr;
        @(posedge refclk);
        model_step(lk, rr);
        @(negedge refclk);
        check_all();
    endtask

    // Assert rst between edges and confirm outputs collapse before the next rising edge.
    task automatic apply_reset();
        #3 rst = 1'b1;
        #1;
        check("arst_pll_rst",  32'(pll_rst),    32'd1);
        check("arst_sys_rst",  32'(sys_rst),    32'd1);
        check("arst_pll_ok",   32'(pll_ok),     32'd0);
        check("arst_pll_fail", 32'(pll_fail),   32'd0);
        check("arst_relock",   32'(relock_cnt), 32'd0);
        model_reset();
        @(negedge refclk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        int fall_e, rise_e, nfall, lat, sys_rise;
        logic prev;
        rst        = 1'b0;
        pll_locked = 1'b0;
        retry_req  = 1'b0;
        model_reset();
        @(negedge refclk);
        apply_reset();

        // Nominal bring-up: lock rises ten cycles after reset release.
        fall_e = -1;
        lat    = -1;
        for (int i = 1; i <= 80; i++) begin
            tick((i > 10) ? 1'b1 : 1'b0, 1'b0);
            if (!pll_rst && fall_e < 0) fall_e = i;
            if (!sys_rst && lat < 0) begin
                lat = i - 10;
                break;
            end
        end
        check("nom_pulse_len", 32'(fall_e), 32'(P_RST));
        check("nom_latency",   32'(lat),    32'(P_STB + 3));
        check("nom_pll_ok",    32'(pll_ok), 32'd1);

        // Lock loss in RUN for three cycles.
        sys_rise = -1;
        rise_e   = -1;
        fall_e   = -1;
        for (int i = 1; i <= 80; i++) begin
            tick((i <= 3) ? 1'b0 : 1'b1, 1'b0);
            if (sys_rst && sys_rise < 0) sys_rise = i;
            if (pll_rst && rise_e < 0) rise_e = i;
            if (!pll_rst && rise_e >= 0 && fall_e < 0) fall_e = i;
            if (pll_ok && i > 3) break;
        end
        check("loss_sys_rst_edge", 32'(sys_rise),        32'd3);
        check("loss_pulse_len",    32'(fall_e - rise_e), 32'(P_RST));
        check("loss_relock",       32'(relock_cnt),      32'd1);
        check("loss_back_to_run",  32'(pll_ok),          32'd1);

        // Permanent loss: three timed-out attempts then FAIL.
        prev   = pll_rst;
        rise_e = -1;
        fall_e = -1;
        nfall  = 0;
        for (int i = 1; i <= 150 && !pll_fail; i++) begin
            tick(1'b0, 1'b0);
            if (pll_rst && !prev) begin
                if (fall_e >= 0) check("tmo_gap", 32'(i - fall_e), 32'(P_TMO));
                rise_e = i;
            end
            if (!pll_rst && prev) begin
                check("tmo_pulse_len", 32'(i - rise_e), 32'(P_RST));
                fall_e = i;
                nfall++;
            end
            prev = pll_rst;
        end
        check("tmo_pulses",   32'(nfall),    32'(P_RETRY));
        check("tmo_pll_fail", 32'(pll_fail), 32'd1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        check("fail_hold_rst", 32'(pll_rst), 32'd1);

        // Recovery from FAIL keeps the relock count.
        tick(1'b0, 1'b1);
        for (int i = 0; i < 100 && !pll_ok; i++) tick(1'b1, 1'b0);
        check("rec_pll_ok", 32'(pll_ok),     32'd1);
        check("rec_relock", 32'(relock_cnt), 32'd2);

        // Repeated lock losses: relock count must stop at 255.
        for (int k = 0; k < 258; k++) begin
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            for (int j = 0; j < 40; j++) begin
                tick(1'b1, 1'b0);
                if (pll_ok && j > 0) break;
            end
        end
        check("sat_relock", 32'(relock_cnt), 32'd255);
        check("sat_pll_ok", 32'(pll_ok),     32'd1);

        // Async reset in the middle of lock qualification.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 60 && m_phase != PH_SETTLE; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        apply_reset();

        // Unstable lock after one timeout: back to waiting, retry count untouched.
        for (int i = 1; i <= 46; i++) tick((i >= 31 && i <= 36) ? 1'b1 : 1'b0, 1'b0);
        check("unst_sys_rst", 32'(sys_rst),           32'd1);
        check("unst_pll_rst", 32'(pll_rst),           32'd0);
        check("unst_retry",   32'(dut.r_retry_cnt),   32'd1);

        // Random lock levels, retry requests and occasional async resets.
        for (int blk = 0; blk < 120; blk++) begin
            logic lv;
            int   len;
            lv  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 100)) : int'($urandom_range(1, 25));
            for (int j = 0; j < len; j++) begin
                tick(lv, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
                if ($urandom_range(0, 999) == 0) apply_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
